// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer feeding a line-buffer KXxKY convolution core.
// A start pulse streams one IXxIY image out of a synchronous image RAM in raster
// order, tags each pixel that completes a full window with its output (x,y)
// coordinate, waits PIPE_LAT cycles for the core to drain, then pulses o_done.
//
// Optional feature macro: CONV_CTRL_STALL_CNT_EN
//   When defined, adds o_stall_cnt (16 bits), a saturating count of FETCH cycles
//   in which the core held off issue (i_core_ready low). Cleared on reset and on
//   an accepted start; holds after o_done.
//
// Handshake: a RAM read is issued in every FETCH cycle where i_core_ready is high
// (o_mem_en). Read data returns one cycle later and is presented to the core with
// o_valid=1 in that cycle. The core must absorb the one pixel already in flight
// after it drops i_core_ready; there is no other flow control on o_valid.
module conv_frame_ctrl #(
    parameter int I_F_BW   = 8,
    parameter int IX       = 28,
    parameter int IY       = 28,
    parameter int KX       = 5,
    parameter int KY       = 5,
    parameter int PIPE_LAT = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_start,
    input  logic                           i_core_ready,
    output logic                           o_mem_en,
    output logic [$clog2(IX*IY)-1:0]       o_mem_addr,
    input  logic [I_F_BW-1:0]              i_mem_data,
    output logic                           o_valid,
    output logic [I_F_BW-1:0]              o_pixel,
    output logic                           o_win_valid,
    output logic [$clog2(IX-KX+1)-1:0]     o_out_x,
    output logic [$clog2(IY-KY+1)-1:0]     o_out_y,
    output logic                           o_busy,
    output logic                           o_done
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                    o_stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Widths and constants, all sized to the counter they are compared to
    // ------------------------------------------------------------------
    localparam int AW = $clog2(IX*IY);
    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;
    localparam int XW = $clog2(IX-KX+1);
    localparam int YW = $clog2(IY-KY+1);
    localparam int DW = $clog2(PIPE_LAT+1);

    localparam logic [AW-1:0] ADDR_LAST  = AW'(IX*IY-1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IX-1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IY-1);
    localparam logic [CW-1:0] COL_WIN    = CW'(KX-1);
    localparam logic [RW-1:0] ROW_WIN    = RW'(KY-1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            issue;
    logic            start_acc;
    logic            win;

    // A start is only honoured while idle; everywhere else it is ignored.
    assign start_acc = (state_q == ST_IDLE) && i_start;

    // One RAM read per FETCH cycle that the core allows.
    assign issue = (state_q == ST_FETCH) && i_core_ready;

    // Next-state, read address and drain counter.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        drain_d   = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_FETCH;
                    rd_addr_d = '0;
                    drain_d   = '0;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    if (rd_addr_q == ADDR_LAST) begin
                        // Last read issued: its pixel appears in the first DRAIN cycle.
                        rd_addr_d = '0;
                        drain_d   = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                rd_addr_d = '0;
                drain_d   = '0;
            end
        endcase
    end

    // Registered status flags decoded from the next state so they align with it.
    always_comb begin
        valid_d = issue;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Raster position of the pixel currently on o_valid.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_acc) begin
            col_d = '0;
            row_d = '0;
        end else if (valid_q) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            drain_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            drain_q   <= drain_d;
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // A pixel completes a window once it sits at or beyond the kernel's
    // bottom-right corner; the output coordinate is that corner's offset.
    assign win = valid_q && (col_q >= COL_WIN) && (row_q >= ROW_WIN);

    assign o_mem_en    = issue;
    assign o_mem_addr  = rd_addr_q;
    assign o_valid     = valid_q;
    assign o_pixel     = i_mem_data;
    assign o_win_valid = win;
    assign o_out_x     = win ? XW'(col_q - COL_WIN) : '0;
    assign o_out_y     = win ? YW'(row_q - ROW_WIN) : '0;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of FETCH cycles held off by the core.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_FETCH) && !i_core_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    // Stall counting is compiled out; no extra port or state.
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with 16-bit pixels so RAM[i]=i+1 can
// hold the full 1..784 value range of a 28x28 frame.
module tb_conv_frame_ctrl;
  localparam int PW = 16;
  localparam int IX = 28;
  localparam int IY = 28;
  localparam int KX = 5;
  localparam int KY = 5;
  localparam int PL = 4;
  localparam int AW = $clog2(IX*IY);
  localparam int XW = $clog2(IX-KX+1);
  localparam int YW = $clog2(IY-KY+1);
  localparam int NPIX = IX*IY;
  localparam int NWIN = (IX-KX+1)*(IY-KY+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_start = 1'b0;
  logic          i_core_ready = 1'b1;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [PW-1:0] i_mem_data = '0;
  logic          o_valid;
  logic [PW-1:0] o_pixel;
  logic          o_win_valid;
  logic [XW-1:0] o_out_x;
  logic [YW-1:0] o_out_y;
  logic          o_busy;
  logic          o_done;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [15:0]   o_stall_cnt;
`endif

  conv_frame_ctrl #(
    .I_F_BW(PW), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_start(i_start),
    .i_core_ready(i_core_ready),
    .o_mem_en(o_mem_en),
    .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data),
    .o_valid(o_valid),
    .o_pixel(o_pixel),
    .o_win_valid(o_win_valid),
    .o_out_x(o_out_x),
    .o_out_y(o_out_y),
    .o_busy(o_busy),
    .o_done(o_done)
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  // Synchronous image RAM model: RAM[a] = a+1, output held while not enabled.
  always @(posedge clk) begin
    if (o_mem_en) i_mem_data <= PW'(o_mem_addr) + PW'(1);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_pix;
  int n_chk = 0;
  int n_bad = 0;
  int t0_g = 0;
  int n_valid, n_win, n_busy, n_done;
  int first_rel, last_rel;
  int first_win_pix, last_win_pix;
  int m_idx, m_col, m_row;
  bit m_win;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_win = 0; n_busy = 0; n_done = 0;
    first_rel = -1; last_rel = -1;
    first_win_pix = -1; last_win_pix = -1;
    exp_q.delete();
    for (int i = 1; i <= NPIX; i++) exp_q.push_back(PW'(i));
  endtask

  // Monitor: samples 1 time unit after each rising edge, checks every pixel
  // against the expected queue and a raster/window model derived from it.
  always @(posedge clk) begin
    #1;
    if (o_busy) n_busy++;
    if (o_done) n_done++;
    if (o_valid) begin
      if (exp_q.size() > 0) exp_pix = exp_q.pop_front();
      else exp_pix = '0;
      m_idx = int'(exp_pix) - 1;
      m_col = m_idx % IX;
      m_row = m_idx / IX;
      m_win = (m_idx >= 0) && (m_col >= KX-1) && (m_row >= KY-1);
      check("pixel", o_pixel, exp_pix);
      check("win_valid", o_win_valid, m_win);
      check("out_x", o_out_x, m_win ? m_col-(KX-1) : 0);
      check("out_y", o_out_y, m_win ? m_row-(KY-1) : 0);
      n_valid++;
      if (n_valid == 1) first_rel = cyc - t0_g;
      last_rel = cyc - t0_g;
      if (o_win_valid) begin
        n_win++;
        if (n_win == 1) first_win_pix = int'(o_pixel);
        last_win_pix = int'(o_pixel);
      end
    end else begin
      check("idle_win", o_win_valid, 0);
      check("idle_x", o_out_x, 0);
      check("idle_y", o_out_y, 0);
    end
  end

  // ---------------- driver ----------------
  // Runs one frame. sa/sb: read address at which the core drops ready for
  // la/lb cycles (negative sa/sb = no stall). hold keeps i_start high until done.
  task automatic run_frame(input int sa, input int la, input int sb, input int lb,
                           input int exp_done, input bit hold);
    int rem;
    int done_rel;
    bit a_done, b_done, seen;
    clear_stats();
    rem = 0; a_done = (sa < 0); b_done = (sb < 0); seen = 0; done_rel = -1;
    @(negedge clk);
    i_start = 1'b1;
    t0_g = cyc;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
`ifdef CONV_CTRL_STALL_CNT_EN
      if (k == 0) check("stall_cnt_clear", o_stall_cnt, 0);
`endif
      if (k == 0) check("busy_t1", o_busy, 1);
      if (o_done) begin
        seen = 1;
        done_rel = cyc - t0_g;
        i_start = 1'b0;
      end else begin
        if (!hold) i_start = 1'b0;
        if (rem > 0) begin
          rem--;
          if (rem == 0) i_core_ready = 1'b1;
        end else if (!a_done && o_busy && int'(o_mem_addr) == sa) begin
          a_done = 1; i_core_ready = 1'b0; rem = la;
        end else if (a_done && !b_done && o_busy && int'(o_mem_addr) == sb) begin
          b_done = 1; i_core_ready = 1'b0; rem = lb;
        end
      end
    end
    i_core_ready = 1'b1;
    check("done_seen", seen, 1);
    check("done_time", done_rel, exp_done);
    check("valid_count", n_valid, NPIX);
    check("first_valid_time", first_rel, 2);
    check("last_valid_time", last_rel, exp_done - PL);
    check("win_count", n_win, NWIN);
    check("first_win_pixel", first_win_pix, 117);
    check("last_win_pixel", last_win_pix, NPIX);
    check("exp_q_left", exp_q.size(), 0);
    check("busy_cycles", n_busy, exp_done);
    check("done_pulses", n_done, 1);
`ifdef CONV_CTRL_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, (sa < 0 ? 0 : la) + (sb < 0 ? 0 : lb));
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_mem_en"}, o_mem_en, 0);
    check({tag, "_mem_addr"}, o_mem_addr, 0);
    check({tag, "_win"}, o_win_valid, 0);
    check({tag, "_x"}, o_out_x, 0);
    check({tag, "_y"}, o_out_y, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("post_reset");

    // Basic frame, then an immediate back-to-back frame.
    run_frame(-1, 0, -1, 0, 789, 1'b0);
    run_frame(-1, 0, -1, 0, 789, 1'b0);

    // Start held high for the whole frame: only one frame may run.
    run_frame(-1, 0, -1, 0, 789, 1'b1);
    repeat (12) @(negedge clk);
    check("hold_no_refire_valid", n_valid, NPIX);
    check("hold_no_refire_done", n_done, 1);
    check_quiet("hold_idle");

    // Backpressure: 10 cycles at pixel 300, 3 cycles at pixel 783.
    run_frame(299, 10, 782, 3, 802, 1'b0);
    repeat (3) @(negedge clk);
`ifdef CONV_CTRL_STALL_CNT_EN
    check("stall_cnt_hold", o_stall_cnt, 13);
`endif

    // Mid-frame reset at pixel 400.
    clear_stats();
    found = 0;
    @(negedge clk);
    i_start = 1'b1;
    t0_g = cyc;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (o_valid && o_pixel == PW'(400)) found = 1;
    end
    check("rst_point_seen", found, 1);
    reset_n = 1'b0;
    #1;
    check_quiet("async_reset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_quiet("no_resume");

    // Fresh frame after the abort must start from pixel 1.
    run_frame(-1, 0, -1, 0, 789, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the line-buffer KX×KY convolution core.
- On a start pulse it streams one IX×IY image from a synchronous image RAM into the core in raster order.
- Tags every pixel that completes a valid window with its output (x,y) coordinate.
- Waits for the core pipeline to drain, then signals frame completion. Sits between the image RAM and the conv core's i_valid/i_pixel inputs.

Parameters:
- I_F_BW, 8, pixel bit width
- IX, 28, image width in pixels
- IY, 28, image height in pixels
- KX, 5, kernel width
- KY, 5, kernel height
- PIPE_LAT, 4, conv core latency in cycles from last pixel accepted to last result out (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- i_start  in  1  frame start pulse; sampled only in IDLE
- i_core_ready  in  1  issue gate from core; core absorbs one in-flight pixel after deassertion
- o_mem_en  out  1  RAM read enable; RAM holds output while low
- o_mem_addr  out  $clog2(IX*IY)  RAM read address
- i_mem_data  in  I_F_BW  RAM read data, valid one cycle after o_mem_en
- o_valid  out  1  pixel valid to core
- o_pixel  out  I_F_BW  pixel to core (equals i_mem_data)
- o_win_valid  out  1  current o_pixel completes a full KX×KY window
- o_out_x  out  $clog2(IX-KX+1)  output column of completed window
- o_out_y  out  $clog2(IY-KY+1)  output row of completed window
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle frame-complete pulse

Behaviour:
- Clock clk, single domain. reset_n is asynchronous, active-low.
- Reset: state IDLE. rd_addr, col, row, drain counter = 0. o_valid, o_busy, o_done, o_mem_en = 0. o_mem_addr, o_out_x, o_out_y = 0.
- Reset mid-frame aborts immediately. No partial-frame state survives; next frame requires a new i_start.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: i_start=1 → FETCH next cycle. o_busy goes 1 in that same next cycle.
- In FETCH, BUSY, DRAIN or DONE, i_start is ignored.
- FETCH issue: o_mem_en = (state==FETCH) && i_core_ready, combinational. o_mem_addr = rd_addr register.
- FETCH advance: rd_addr increments on each issue.
- FETCH exit: the issue with rd_addr==IX*IY-1 moves to DRAIN on the next cycle; rd_addr returns to 0.
- o_valid is a register equal to the previous cycle's o_mem_en. o_pixel = i_mem_data.
- No pixel is dropped or duplicated under any i_core_ready pattern. Deasserting i_core_ready for N cycles delays all later traffic by exactly N cycles.
- Position counters (col, row) describe the pixel on o_valid and advance when o_valid=1.
- col wraps IX-1→0 and increments row. row wraps IY-1→0 at end of frame.
- o_win_valid = o_valid && col≥KX-1 && row≥KY-1, combinational.
- o_out_x = col-(KX-1), o_out_y = row-(KY-1). Both are meaningful only when o_win_valid=1 and are 0 otherwise.
- Exactly (IX-KX+1)*(IY-KY+1) o_win_valid cycles per frame.
- DRAIN: the last pixel's o_valid occurs in the first DRAIN cycle. The drain counter counts PIPE_LAT cycles, then moves to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=1 in that cycle, then IDLE.
- An i_start in the DONE cycle is ignored. i_start in the first IDLE cycle after DONE is accepted, so frames can run back-to-back.
- Arithmetic: all counters are unsigned. Comparisons are done at counter width with no overflow.

Optional Feature:
- Macro: CONV_CTRL_STALL_CNT_EN.
- When defined: extra port o_stall_cnt, out, 16 bits. Counts cycles in FETCH with i_core_ready=0. Cleared on reset and on accepted i_start. Saturates at 16'hFFFF. Holds its value after o_done.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame, defaults, RAM[i]=i+1, i_core_ready=1, i_start at cycle t0:
  - 784 o_valid pulses carrying pixels 1..784 in order, during t2..t785.
  - o_done single pulse at t789; o_busy high from t1 through t789.
- Window tagging:
  - First o_win_valid on pixel value 117 with (x,y)=(0,0).
  - Pixel 140 gives (23,0); pixel 145 gives (0,1); last is pixel 784 with (23,23).
  - Total 576 o_win_valid pulses.
- Backpressure: i_core_ready low for 10 cycles at pixel 300 and 3 cycles at pixel 783:
  - Pixel stream still 1..784 with no gaps in value.
  - o_done at t802.
- Start handling: i_start held high through the frame → exactly one frame runs. i_start in the cycle after o_done → second identical frame with o_done 789 cycles later.
- Mid-frame reset: reset_n low at pixel 400 → all outputs 0 asynchronously. After release, i_start → full fresh frame beginning at pixel 1.
- With CONV_CTRL_STALL_CNT_EN: the backpressure scenario → o_stall_cnt=13 after o_done. The next i_start clears it to 0.
